// File: rtl/gb_int_pkg.sv
// Shared types and constants for the Game Boy interrupt controller.
// Optional build macro: GB_INT_VECTOR_EN (see gb_int_ctrl).
package gb_int_pkg;

  typedef enum logic [2:0] {
    VBLANK   = 3'd0,
    LCD_STAT = 3'd1,
    TIMER    = 3'd2,
    SERIAL   = 3'd3,
    JOYPAD   = 3'd4
  } gb_irq_e;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;
  localparam int          NUM_IRQ = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } gb_int_state_e;

  // One-hot mask for a source index; out-of-range indices give no bit.
  function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [2:0] idx);
    case (idx)
      3'd0:    irq_onehot = 5'b00001;
      3'd1:    irq_onehot = 5'b00010;
      3'd2:    irq_onehot = 5'b00100;
      3'd3:    irq_onehot = 5'b01000;
      3'd4:    irq_onehot = 5'b10000;
      default: irq_onehot = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/gb_int_prio.sv
// Five-input priority encoder: the lowest set bit index wins.
module gb_int_prio
  import gb_int_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [2:0]         idx,
  output logic               any
);

  // Lowest index has the highest priority
  always_comb begin
    idx = 3'd0;
    any = |req;
    casez (req)
      5'b????1: idx = 3'd0;
      5'b???10: idx = 3'd1;
      5'b??100: idx = 3'd2;
      5'b?1000: idx = 3'd3;
      5'b10000: idx = 3'd4;
      default:  idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/gb_int_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, int_n generation and the acknowledge handshake.
// Define GB_INT_VECTOR_EN to have the controller drive the vector byte during acknowledge.
module gb_int_ctrl
  import gb_int_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = 8'h40
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        A,
  input  logic [7:0]         wdata,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic               int_n,
  output logic [7:0]         rdata,
  output logic               rsel,
  output logic [NUM_IRQ-1:0] irq_ack
);

  gb_int_state_e      state_r;
  gb_int_state_e      state_n;
  logic [NUM_IRQ-1:0] if_r;
  logic [NUM_IRQ-1:0] if_next_s;
  logic [7:0]         ie_r;
  logic               wr_prev_r;
  logic               wr_strobe_s;
  logic               rd_strobe_s;
  logic               wr_if_s;
  logic               wr_ie_s;
  logic               rd_if_s;
  logic               rd_ie_s;
  logic [NUM_IRQ-1:0] pending_s;
  logic [2:0]         prio_idx_s;
  logic               prio_any_s;
  logic               ack_start_s;
  logic [NUM_IRQ-1:0] ack_clr_s;

  // A write only counts on the first cycle of a strobe, so wait states cannot repeat it
  assign wr_strobe_s = !mreq_n && !wr_n;
  assign rd_strobe_s = !mreq_n && !rd_n;
  assign wr_if_s     = wr_strobe_s && !wr_prev_r && (A == ADDR_IF);
  assign wr_ie_s     = wr_strobe_s && !wr_prev_r && (A == ADDR_IE);
  assign rd_if_s     = rd_strobe_s && (A == ADDR_IF);
  assign rd_ie_s     = rd_strobe_s && (A == ADDR_IE);

  assign pending_s   = if_r & ie_r[NUM_IRQ-1:0];

  gb_int_prio u_prio (
    .req (pending_s),
    .idx (prio_idx_s),
    .any (prio_any_s)
  );

  assign ack_clr_s = (ack_start_s && prio_any_s) ? irq_onehot(prio_idx_s) : 5'b00000;

  // Acknowledge handshake sequencing
  always_comb begin
    state_n     = state_r;
    ack_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!m1_n && !iorq_n) begin
          state_n     = ACK;
          ack_start_s = 1'b1;
        end else begin
          state_n     = IDLE;
        end
      end
      ACK: begin
        if (iorq_n) begin
          state_n = DONE;
        end else begin
          state_n = ACK;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A new request pulse beats both a same-cycle write of 0 and the acknowledge clear
  always_comb begin
    if_next_s = if_r;
    if (wr_if_s) begin
      if_next_s = wdata[NUM_IRQ-1:0];
    end else begin
      if_next_s = if_r;
    end
    if_next_s = (if_next_s & ~ack_clr_s) | irq_req;
  end

  // Register file, FSM state and registered CPU-facing outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      if_r      <= 5'b00000;
      ie_r      <= 8'h00;
      wr_prev_r <= 1'b0;
      int_n     <= 1'b1;
      irq_ack   <= 5'b00000;
    end else begin
      state_r   <= state_n;
      if_r      <= if_next_s;
      wr_prev_r <= wr_strobe_s;
      if (wr_ie_s) begin
        ie_r <= wdata;
      end
      // Held high through the whole handshake so IME can be cleared before it reasserts
      int_n     <= (state_n == IDLE) ? ~|pending_s : 1'b1;
      irq_ack   <= ack_clr_s;
    end
  end

`ifdef GB_INT_VECTOR_EN
  logic [2:0] sel_r;
  logic       none_r;

  // Remember which source is being serviced for the vector byte
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_r  <= 3'd0;
      none_r <= 1'b0;
    end else if (ack_start_s) begin
      sel_r  <= prio_any_s ? prio_idx_s : 3'd0;
      none_r <= !prio_any_s;
    end
  end
`endif

  // Read data toward the CPU di mux; the vector takes precedence during acknowledge
  always_comb begin
    rsel  = 1'b0;
    rdata = 8'hFF;
`ifdef GB_INT_VECTOR_EN
    if ((state_r == ACK) && !iorq_n) begin
      rsel  = 1'b1;
      rdata = none_r ? 8'hFF : (VEC_BASE + {2'b00, sel_r, 3'b000});
    end else
`endif
    if (rd_if_s) begin
      rsel  = 1'b1;
      rdata = {3'b111, if_r};
    end else if (rd_ie_s) begin
      rsel  = 1'b1;
      rdata = ie_r;
    end else begin
      rsel  = 1'b0;
      rdata = 8'hFF;
    end
  end

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Directed self-checking bench for gb_int_ctrl: vector table plus hand-written handshake sequences.
module tb_gb_int_ctrl;
  import gb_int_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  wdata;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [4:0]  irq_req;
  logic        int_n;
  logic [7:0]  rdata;
  logic        rsel;
  logic [4:0]  irq_ack;

  int checks = 0;
  int errors = 0;

  gb_int_ctrl #(.VEC_BASE(8'h40)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .wdata(wdata),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .irq_req(irq_req), .int_n(int_n), .rdata(rdata), .rsel(rsel), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 idle, 1 write, 2 read
  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [4:0]  irq;
    logic        exp_rsel;
    logic [7:0]  exp_rdata;
    logic        exp_int_n;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    A = 16'h0000; wdata = 8'h00; mreq_n = 1'b1; iorq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; irq_req = 5'b00000;
  endtask

  task automatic set_wr(input logic [15:0] addr, input logic [7:0] data);
    A = addr; wdata = data; mreq_n = 1'b0; wr_n = 1'b0;
  endtask

  task automatic set_rd(input logic [15:0] addr);
    A = addr; mreq_n = 1'b0; rd_n = 1'b0;
  endtask

  initial begin
    //           kind  addr     data   irq       rsel  rdata  int_n
    vecs[0]  = '{2'd0, 16'h0000, 8'h00, 5'b00000, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{2'd2, ADDR_IF,  8'h00, 5'b00000, 1'b1, 8'hE0, 1'b1};
    vecs[2]  = '{2'd2, ADDR_IE,  8'h00, 5'b00000, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{2'd1, ADDR_IE,  8'h05, 5'b00000, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{2'd0, 16'h0000, 8'h00, 5'b00100, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{2'd2, ADDR_IF,  8'h00, 5'b00000, 1'b1, 8'hE4, 1'b1};
    vecs[6]  = '{2'd0, 16'h0000, 8'h00, 5'b00000, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{2'd1, ADDR_IF,  8'h00, 5'b00010, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{2'd2, ADDR_IF,  8'h00, 5'b00000, 1'b1, 8'hE2, 1'b0};
    vecs[9]  = '{2'd0, 16'h0000, 8'h00, 5'b00000, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{2'd2, ADDR_IE,  8'h00, 5'b00000, 1'b1, 8'h05, 1'b1};
    vecs[11] = '{2'd1, ADDR_IE,  8'hA2, 5'b00000, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{2'd2, ADDR_IE,  8'h00, 5'b00000, 1'b1, 8'hA2, 1'b1};
    vecs[13] = '{2'd0, 16'h0000, 8'h00, 5'b00000, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{2'd1, ADDR_IF,  8'h00, 5'b00000, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{2'd0, 16'h0000, 8'h00, 5'b00000, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{2'd2, ADDR_IF,  8'h00, 5'b00000, 1'b1, 8'hE0, 1'b1};

    bus_idle();
    reset_n = 1'b0;
    tick();
    tick();
    chk("reset_int_n", {7'b0, int_n}, 8'h01);
    chk("reset_irq_ack", {3'b0, irq_ack}, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      tick();
      bus_idle();
      if (vecs[i].kind == 2'd1) set_wr(vecs[i].addr, vecs[i].data);
      else if (vecs[i].kind == 2'd2) set_rd(vecs[i].addr);
      irq_req = vecs[i].irq;
      #1;
      chk($sformatf("vec%0d_rsel", i), {7'b0, rsel}, {7'b0, vecs[i].exp_rsel});
      if (vecs[i].exp_rsel) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_int_n", i), {7'b0, int_n}, {7'b0, vecs[i].exp_int_n});
      chk($sformatf("vec%0d_irq_ack", i), {3'b0, irq_ack}, 8'h00);
    end

    // Acknowledge of IF=00101 with IE=1F, iorq_n low for three cycles
    tick(); bus_idle(); set_wr(ADDR_IE, 8'h1F);
    tick(); bus_idle();
    tick(); bus_idle(); set_wr(ADDR_IF, 8'h05);
    tick(); bus_idle();
    tick(); bus_idle();
    #1 chk("ack_pre_int_n", {7'b0, int_n}, 8'h00);
    tick(); bus_idle(); m1_n = 1'b0; iorq_n = 1'b0;
    #1 chk("ack_c0_int_n", {7'b0, int_n}, 8'h00);
    chk("ack_c0_rsel", {7'b0, rsel}, 8'h00);
    tick();
    #1 chk("ack_c1_irq_ack", {3'b0, irq_ack}, 8'h01);
    chk("ack_c1_int_n", {7'b0, int_n}, 8'h01);
`ifdef GB_INT_VECTOR_EN
    chk("ack_c1_rsel", {7'b0, rsel}, 8'h01);
    chk("ack_c1_vector", rdata, 8'h40);
`else
    chk("ack_c1_rsel", {7'b0, rsel}, 8'h00);
`endif
    tick();
    #1 chk("ack_c2_irq_ack", {3'b0, irq_ack}, 8'h00);
    chk("ack_c2_int_n", {7'b0, int_n}, 8'h01);
    tick(); bus_idle();
    #1 chk("ack_c3_rsel", {7'b0, rsel}, 8'h00);
    chk("ack_c3_int_n", {7'b0, int_n}, 8'h01);
    tick();
    #1 chk("ack_done_int_n", {7'b0, int_n}, 8'h01);
    tick();
    #1 chk("ack_after_int_n", {7'b0, int_n}, 8'h00);
    set_rd(ADDR_IF);
    #1 chk("ack_if_after", rdata, 8'hE4);

    // Acknowledge with nothing pending: no clear, no pulse
    tick(); bus_idle(); set_wr(ADDR_IE, 8'h00);
    tick(); bus_idle();
    tick(); bus_idle(); m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    #1 chk("none_irq_ack", {3'b0, irq_ack}, 8'h00);
`ifdef GB_INT_VECTOR_EN
    chk("none_vector", rdata, 8'hFF);
`endif
    tick(); bus_idle();
    tick();
    tick(); set_rd(ADDR_IF);
    #1 chk("none_if_kept", rdata, 8'hE4);

    // Write strobe held for three cycles while the timer pulses in the second
    tick(); bus_idle(); set_wr(ADDR_IF, 8'h00);
    tick(); bus_idle();
    tick(); set_wr(ADDR_IF, 8'h1F);
    tick(); irq_req = 5'b00100;
    tick(); irq_req = 5'b00000;
    tick(); bus_idle(); set_rd(ADDR_IF);
    #1 chk("hold_wr_1f", rdata, 8'hFF);
    tick(); bus_idle(); set_wr(ADDR_IF, 8'h00);
    tick(); irq_req = 5'b10000;
    tick(); irq_req = 5'b00000;
    tick(); bus_idle(); set_rd(ADDR_IF);
    #1 chk("hold_wr_single", rdata, 8'hF0);

    // Reset in the middle of an acknowledge
    tick(); bus_idle(); set_wr(ADDR_IE, 8'h1F);
    tick(); bus_idle();
    tick(); bus_idle(); m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    #1 chk("rst_ack_pulse", {3'b0, irq_ack}, 8'h10);
    reset_n = 1'b0;
    tick(); bus_idle();
    #1 chk("rst_irq_ack", {3'b0, irq_ack}, 8'h00);
    chk("rst_rsel", {7'b0, rsel}, 8'h00);
    chk("rst_int_n", {7'b0, int_n}, 8'h01);
    reset_n = 1'b1;
    tick(); set_rd(ADDR_IF);
    #1 chk("rst_if", rdata, 8'hE0);
    tick(); bus_idle(); set_rd(ADDR_IE);
    #1 chk("rst_ie", rdata, 8'h00);
    tick(); bus_idle(); set_wr(ADDR_IE, 8'h01);
    tick(); bus_idle(); irq_req = 5'b00001;
    tick(); bus_idle();
    tick();
    #1 chk("rst_fsm_idle_int_n", {7'b0, int_n}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
